// File: rtl/sram_bist_pkg.sv
// Shared types and the March C- table for the SRAM BIST controller.
package sram_bist_pkg;

   typedef enum logic [1:0] {
      W0 = 2'd0,
      W1 = 2'd1,
      R0 = 2'd2,
      R1 = 2'd3
   } march_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_t;

   localparam int MARCH_NUM_ELEM = 6;
   localparam int MARCH_MAX_OPS  = 2;

   // Single-op elements pad their second slot; it is never reached.
   localparam logic [1:0] MARCH_OP_CNT [MARCH_NUM_ELEM] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   localparam march_op_t MARCH_OPS [MARCH_NUM_ELEM][MARCH_MAX_OPS] = '{
      '{W0, W0},
      '{R0, W1},
      '{R1, W0},
      '{R0, W1},
      '{R1, W0},
      '{R0, R0}
   };

   localparam logic MARCH_DOWN [MARCH_NUM_ELEM] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   function automatic logic op_is_read(input march_op_t op);
      return op inside {R0, R1};
   endfunction

   function automatic logic op_value(input march_op_t op);
      return op inside {W1, R1};
   endfunction

endpackage

// File: rtl/sram_march_seq.sv
// March sequencer: walks element / op / address and presents the op to issue next.
module sram_march_seq
   import sram_bist_pkg::*;
#(
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   output march_op_t             op,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [2:0]            elem,
   output logic                  last
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   logic [2:0]            elem_q, elem_d;
   logic                  op_idx_q, op_idx_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  op_last, addr_term, elem_last;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      elem_d   = elem_q;
      op_idx_d = op_idx_q;
      addr_d   = addr_q;

      op_last   = ({1'b0, op_idx_q} == (MARCH_OP_CNT[elem_q] - 2'd1));
      addr_term = MARCH_DOWN[elem_q] ? (addr_q == '0) : (addr_q == ADDR_MAX);
      elem_last = (elem_q == 3'(MARCH_NUM_ELEM - 1));
      last      = elem_last && op_last && addr_term;

      if (advance) begin
         if (!op_last) begin
            op_idx_d = 1'b1;
         end else begin
            op_idx_d = 1'b0;
            if (!addr_term) begin
               addr_d = MARCH_DOWN[elem_q] ? (addr_q - 1'b1) : (addr_q + 1'b1);
            end else if (elem_last) begin
               // Wrap to the initial position so the next start needs no extra clear.
               elem_d = '0;
               addr_d = '0;
            end else begin
               elem_d = elem_q + 3'd1;
               addr_d = MARCH_DOWN[elem_d] ? ADDR_MAX : '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (rst) begin
         elem_q   <= '0;
         op_idx_q <= 1'b0;
         addr_q   <= '0;
      end else begin
         elem_q   <= elem_d;
         op_idx_q <= op_idx_d;
         addr_q   <= addr_d;
      end
   end

   assign op   = MARCH_OPS[elem_q][op_idx_q];
   assign addr = addr_q;
   assign elem = elem_q;

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for one single-port SRAM macro: FSM, registered pins,
// one-cycle-delayed read compare and first-fail / fail-count capture.
module sram_march_bist_ctrl
   import sram_bist_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 9,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    WMASK_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] BG_PATTERN  = '0,
   parameter int                    CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   fail,
   output logic [CNT_WIDTH-1:0]   fail_count,
   output logic [ADDR_WIDTH-1:0]  fail_addr,
   output logic [2:0]             fail_elem,
   output logic [DATA_WIDTH-1:0]  fail_data,
   output logic                   sram_we,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   ctrl_state_t state_q, state_d;

   logic                   sram_we_q, sram_we_d;
   logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
   logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0]  sram_din_q, sram_din_d;
   logic                   rd_q, rd_d;
   logic [DATA_WIDTH-1:0]  rd_exp_q, rd_exp_d;
   logic [2:0]             rd_elem_q, rd_elem_d;
   logic                   last_q, last_d;

   logic                   cmp_valid_q, cmp_valid_d;
   logic [DATA_WIDTH-1:0]  cmp_exp_q, cmp_exp_d;
   logic [ADDR_WIDTH-1:0]  cmp_addr_q, cmp_addr_d;
   logic [2:0]             cmp_elem_q, cmp_elem_d;

   logic                   fail_q, fail_d;
   logic [CNT_WIDTH-1:0]   fail_count_q, fail_count_d;
   logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
   logic [2:0]             fail_elem_q, fail_elem_d;
   logic [DATA_WIDTH-1:0]  fail_data_q, fail_data_d;

   march_op_t             seq_op;
   logic [ADDR_WIDTH-1:0] seq_addr;
   logic [2:0]            seq_elem;
   logic                  seq_last;
   logic                  start_acc, issue, miss;
   logic [DATA_WIDTH-1:0] seq_pat;

   sram_march_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_seq (
      .clk     (clk),
      .rst     (rst),
      .advance (issue),
      .op      (seq_op),
      .addr    (seq_addr),
      .elem    (seq_elem),
      .last    (seq_last)
   );

   always_comb begin
      start_acc = start && (state_q == IDLE || state_q == DONE);
      issue     = start_acc || (state_q == RUN && !last_q);
      seq_pat   = op_value(seq_op) ? ~BG_PATTERN : BG_PATTERN;
      miss      = cmp_valid_q && (sram_dout != cmp_exp_q);

      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_q) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase

      sram_we_d    = 1'b0;
      sram_wmask_d = '0;
      sram_addr_d  = sram_addr_q;
      sram_din_d   = sram_din_q;
      rd_d         = 1'b0;
      rd_exp_d     = rd_exp_q;
      rd_elem_d    = rd_elem_q;
      last_d       = 1'b0;
      if (issue) begin
         sram_we_d    = !op_is_read(seq_op);
         sram_wmask_d = {WMASK_WIDTH{!op_is_read(seq_op)}};
         sram_addr_d  = seq_addr;
         sram_din_d   = seq_pat;
         rd_d         = op_is_read(seq_op);
         rd_exp_d     = seq_pat;
         rd_elem_d    = seq_elem;
         last_d       = seq_last;
      end

      // The macro returns read data one cycle after the read edge, hence the extra stage.
      cmp_valid_d = rd_q;
      cmp_exp_d   = rd_exp_q;
      cmp_addr_d  = sram_addr_q;
      cmp_elem_d  = rd_elem_q;

      fail_d       = fail_q;
      fail_count_d = fail_count_q;
      fail_addr_d  = fail_addr_q;
      fail_elem_d  = fail_elem_q;
      fail_data_d  = fail_data_q;
      if (start_acc) begin
         fail_d       = 1'b0;
         fail_count_d = '0;
         fail_addr_d  = '0;
         fail_elem_d  = '0;
         fail_data_d  = '0;
      end else if (miss) begin
         fail_d = 1'b1;
         if (fail_count_q != '1) fail_count_d = fail_count_q + 1'b1;
         if (!fail_q) begin
            fail_addr_d = cmp_addr_q;
            fail_elem_d = cmp_elem_q;
            fail_data_d = sram_dout;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sram_we_q    <= 1'b0;
         sram_wmask_q <= '0;
         sram_addr_q  <= '0;
         sram_din_q   <= '0;
         rd_q         <= 1'b0;
         rd_exp_q     <= '0;
         rd_elem_q    <= '0;
         last_q       <= 1'b0;
         cmp_valid_q  <= 1'b0;
         cmp_exp_q    <= '0;
         cmp_addr_q   <= '0;
         cmp_elem_q   <= '0;
         fail_q       <= 1'b0;
         fail_count_q <= '0;
         fail_addr_q  <= '0;
         fail_elem_q  <= '0;
         fail_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         sram_we_q    <= sram_we_d;
         sram_wmask_q <= sram_wmask_d;
         sram_addr_q  <= sram_addr_d;
         sram_din_q   <= sram_din_d;
         rd_q         <= rd_d;
         rd_exp_q     <= rd_exp_d;
         rd_elem_q    <= rd_elem_d;
         last_q       <= last_d;
         cmp_valid_q  <= cmp_valid_d;
         cmp_exp_q    <= cmp_exp_d;
         cmp_addr_q   <= cmp_addr_d;
         cmp_elem_q   <= cmp_elem_d;
         fail_q       <= fail_d;
         fail_count_q <= fail_count_d;
         fail_addr_q  <= fail_addr_d;
         fail_elem_q  <= fail_elem_d;
         fail_data_q  <= fail_data_d;
      end
   end

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign fail       = fail_q;
   assign fail_count = fail_count_q;
   assign fail_addr  = fail_addr_q;
   assign fail_elem  = fail_elem_q;
   assign fail_data  = fail_data_q;
   assign sram_we    = sram_we_q;
   assign sram_wmask = sram_wmask_q;
   assign sram_addr  = sram_addr_q;
   assign sram_din   = sram_din_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for sram_march_bist_ctrl with a behavioural 512x32 macro and
// per-address stuck-at fault masks.
module tb_sram_march_bist_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        fail;
   logic [15:0] fail_count;
   logic [8:0]  fail_addr;
   logic [2:0]  fail_elem;
   logic [31:0] fail_data;
   logic        sram_we;
   logic [3:0]  sram_wmask;
   logic [8:0]  sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout;

   logic [31:0] mem [512];
   logic [31:0] sa0 [512];
   logic [31:0] sa1 [512];

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;
   int mask_bad = 0;
   int busy_cnt = 0;
   logic mon_en = 1'b0;
   int dc;

   sram_march_bist_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_count (fail_count),
      .fail_addr  (fail_addr),
      .fail_elem  (fail_elem),
      .fail_data  (fail_data),
      .sram_we    (sram_we),
      .sram_wmask (sram_wmask),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural macro: registered read, X on write cycles, stuck-at masks on read.
   always @(posedge clk) begin
      if (sram_we) begin
         for (int b = 0; b < 4; b++)
            if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         sram_dout <= 'x;
      end else begin
         sram_dout <= (mem[sram_addr] & ~sa0[sram_addr]) | sa1[sram_addr];
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (sram_we) begin
            wr_cnt++;
            if (sram_wmask !== 4'hF) mask_bad++;
         end
         if (busy) busy_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < 512; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
   endtask

   task automatic check_cleared(input string pfx);
      check({pfx, "_busy"},       busy,       0);
      check({pfx, "_done"},       done,       0);
      check({pfx, "_fail"},       fail,       0);
      check({pfx, "_fail_count"}, fail_count, 0);
      check({pfx, "_fail_addr"},  fail_addr,  0);
      check({pfx, "_fail_elem"},  fail_elem,  0);
      check({pfx, "_fail_data"},  fail_data,  0);
      check({pfx, "_sram_we"},    sram_we,    0);
      check({pfx, "_sram_wmask"}, sram_wmask, 0);
      check({pfx, "_sram_addr"},  sram_addr,  0);
      check({pfx, "_sram_din"},   sram_din,   0);
   endtask

   // Pulses start at E0, optionally pulses start again during cycles pa/pb,
   // and returns the first cycle number in which done is seen (0 on timeout).
   task automatic run_test(input int pa, input int pb, output int done_cyc);
      done_cyc = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      wr_cnt   = 0;
      mask_bad = 0;
      busy_cnt = 0;
      mon_en   = 1'b1;
      check("c1_busy",       busy,       1);
      check("c1_done",       done,       0);
      check("c1_fail",       fail,       0);
      check("c1_fail_count", fail_count, 0);
      for (int k = 1; k <= 6000; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            done_cyc = k + 1;
            break;
         end
         if (k + 1 == pa || k + 1 == pb) start = 1'b1;
      end
      mon_en = 1'b0;
      check("done_cycle",   done_cyc, 5122);
      check("busy_at_done", busy,     0);
      check("busy_cycles",  busy_cnt, 5121);
      check("write_cycles", wr_cnt,   2560);
      check("wmask_bad",    mask_bad, 0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      clear_faults();
      repeat (3) @(posedge clk);
      #1;
      check_cleared("reset");
      rst = 1'b0;

      // Fault-free run
      run_test(0, 0, dc);
      check("clean_fail",       fail,       0);
      check("clean_fail_count", fail_count, 0);

      // Bit 5 of 0x1A3 stuck-at-0: caught by r1 in elements 2 and 4
      sa0[9'h1A3] = 32'h0000_0020;
      run_test(0, 0, dc);
      check("sa0_fail",       fail,       1);
      check("sa0_fail_addr",  fail_addr,  9'h1A3);
      check("sa0_fail_elem",  fail_elem,  2);
      check("sa0_fail_data",  fail_data,  32'hFFFF_FFDF);
      check("sa0_fail_count", fail_count, 2);

      repeat (3) @(posedge clk);
      #1;
      check("done_held", done, 1);
      check("fail_held", fail, 1);

      // Bit 0 stuck-at-1 at both ends of the array: r0 in elements 1, 3, 5
      clear_faults();
      sa1[9'h000] = 32'h0000_0001;
      sa1[9'h1FF] = 32'h0000_0001;
      run_test(0, 0, dc);
      check("sa1_fail",       fail,       1);
      check("sa1_fail_addr",  fail_addr,  9'h000);
      check("sa1_fail_elem",  fail_elem,  1);
      check("sa1_fail_data",  fail_data,  32'h0000_0001);
      check("sa1_fail_count", fail_count, 6);

      // Restart from DONE with the fault gone: results must clear
      clear_faults();
      run_test(0, 0, dc);
      check("rerun_fail",       fail,       0);
      check("rerun_fail_count", fail_count, 0);

      // start pulses during RUN and DRAIN are ignored
      run_test(100, 5121, dc);
      check("pulse_fail", fail, 0);

      // Reset during cycle 2000 aborts a failing run
      sa1[9'h000] = 32'h0000_0001;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (1999) @(posedge clk);
      #1;
      check("abort_pre_busy", busy, 1);
      check("abort_pre_fail", fail, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_cleared("abort");
      clear_faults();
      run_test(0, 0, dc);
      check("post_abort_fail",       fail,       0);
      check("post_abort_fail_count", fail_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
